// File: rtl/reversi_move_ctrl.sv
// reversi_move_ctrl: cursor/turn controller between the key decoder and the board RAM.
// Moves a wrapping cursor in IDLE and runs a read-check-write placement on enter.
// Optional build macro REVERSI_REJECT_COUNT_EN adds the rejectCount output, which
// counts consecutive rejected placements (saturating, cleared by a successful one).
module reversi_move_ctrl #(
    parameter int BOARD_DIM = 8,
    parameter int COORD_W   = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enterEn,
    input  logic                   moveRightEn,
    input  logic                   moveLeftEn,
    input  logic                   moveUpEn,
    input  logic                   moveDownEn,
    input  logic [1:0]             cellRdData,
    output logic [COORD_W-1:0]     cursorX,
    output logic [COORD_W-1:0]     cursorY,
    output logic [2*COORD_W-1:0]   cellAddr,
    output logic                   cellWrEn,
    output logic [1:0]             cellWrData,
    output logic                   currentPlayer,
    output logic                   busy,
    output logic                   placeOk,
`ifdef REVERSI_REJECT_COUNT_EN
    output logic                   placeReject,
    output logic [7:0]             rejectCount
`else
    output logic                   placeReject
`endif
);

    // Key strobes are accepted only while busy is low; a strobe arriving while
    // busy is high is dropped, never queued. Outputs placeOk/placeReject are
    // single-cycle result strobes with no back-pressure.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(BOARD_DIM - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    state_t               state_q;
    logic [COORD_W-1:0]   cur_x_q;
    logic [COORD_W-1:0]   cur_y_q;
    logic [COORD_W-1:0]   cur_x_d;
    logic [COORD_W-1:0]   cur_y_d;
    logic                 player_q;
    logic                 wr_en_q;
    logic [1:0]           wr_data_q;
    logic                 place_ok_q;
    logic                 place_reject_q;

    // Next cursor position from the move keys: one move only, right > left > up > down
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (moveRightEn) begin
            cur_x_d = (cur_x_q == COORD_MAX) ? '0 : cur_x_q + COORD_ONE;
        end else if (moveLeftEn) begin
            cur_x_d = (cur_x_q == '0) ? COORD_MAX : cur_x_q - COORD_ONE;
        end else if (moveUpEn) begin
            cur_y_d = (cur_y_q == '0) ? COORD_MAX : cur_y_q - COORD_ONE;
        end else if (moveDownEn) begin
            cur_y_d = (cur_y_q == COORD_MAX) ? '0 : cur_y_q + COORD_ONE;
        end
    end

    // Placement FSM with registered cursor, player and result strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            player_q       <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= 2'b01;
            place_ok_q     <= 1'b0;
            place_reject_q <= 1'b0;
        end else begin
            wr_en_q        <= 1'b0;
            place_ok_q     <= 1'b0;
            place_reject_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Enter wins over any move in the same cycle; cursor freezes.
                    if (enterEn) begin
                        state_q <= ST_READ;
                    end else begin
                        cur_x_q <= cur_x_d;
                        cur_y_q <= cur_y_d;
                    end
                end
                ST_READ: begin
                    // Address was presented in this cycle; data arrives next cycle.
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (cellRdData == 2'b00) begin
                        state_q <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else begin
                        state_q        <= ST_IDLE;
                        place_reject_q <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q    <= ST_IDLE;
                    player_q   <= ~player_q;
                    wr_data_q  <= player_q ? 2'b01 : 2'b10;
                    place_ok_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REVERSI_REJECT_COUNT_EN
    logic [7:0] reject_cnt_q;

    // Consecutive-reject counter: cleared by a successful placement, saturates at 255
    always_ff @(posedge clk) begin
        if (reset) begin
            reject_cnt_q <= '0;
        end else if (place_ok_q) begin
            reject_cnt_q <= '0;
        end else if (place_reject_q && (reject_cnt_q != 8'hFF)) begin
            reject_cnt_q <= reject_cnt_q + 8'd1;
        end
    end

    assign rejectCount = reject_cnt_q;
`endif

    assign cursorX       = cur_x_q;
    assign cursorY       = cur_y_q;
    assign cellAddr      = {cur_y_q, cur_x_q};
    assign cellWrEn      = wr_en_q;
    assign cellWrData    = wr_data_q;
    assign currentPlayer = player_q;
    assign busy          = (state_q != ST_IDLE);
    assign placeOk       = place_ok_q;
    assign placeReject   = place_reject_q;

endmodule

// File: tb/tb_reversi_move_ctrl.sv
// tb_reversi_move_ctrl: directed bench for reversi_move_ctrl with a board RAM model
// and an expected-event scoreboard (write, ok, reject) timestamped by cycle.
module tb_reversi_move_ctrl;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       enterEn, moveRightEn, moveLeftEn, moveUpEn, moveDownEn;
  logic [1:0] cellRdData;
  logic [2:0] cursorX, cursorY;
  logic [5:0] cellAddr;
  logic       cellWrEn;
  logic [1:0] cellWrData;
  logic       currentPlayer, busy, placeOk, placeReject;
`ifdef REVERSI_REJECT_COUNT_EN
  logic [7:0] rejectCount;
`endif

  reversi_move_ctrl #(.BOARD_DIM(8), .COORD_W(3)) dut (
    .clk(clk), .reset(reset),
    .enterEn(enterEn), .moveRightEn(moveRightEn), .moveLeftEn(moveLeftEn),
    .moveUpEn(moveUpEn), .moveDownEn(moveDownEn),
    .cellRdData(cellRdData),
    .cursorX(cursorX), .cursorY(cursorY), .cellAddr(cellAddr),
    .cellWrEn(cellWrEn), .cellWrData(cellWrData),
    .currentPlayer(currentPlayer), .busy(busy),
    .placeOk(placeOk),
`ifdef REVERSI_REJECT_COUNT_EN
    .placeReject(placeReject),
    .rejectCount(rejectCount)
`else
    .placeReject(placeReject)
`endif
  );

  // board RAM environment: 1-cycle synchronous read, write on strobe
  logic [1:0] ram [64];
  always @(posedge clk) begin
    cellRdData <= ram[cellAddr];
    if (cellWrEn) ram[cellAddr] <= cellWrData;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected model
  int mx, my, mp, rej_model;
  int bd_model [64];

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [W-1:0] mk(input int kind, input int addr, input int data,
                                      input int player, input int c);
    logic [1:0] k2; logic [5:0] a6; logic [1:0] d2; logic p1; logic [15:0] c16;
    k2 = kind[1:0]; a6 = addr[5:0]; d2 = data[1:0]; p1 = player[0]; c16 = c[15:0];
    return {k2, a6, d2, p1, 5'd0, c16};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_evt(input string nm, input logic [W-1:0] got);
    logic [W-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event got %h expected none", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, got, e);
      end
    end
  endtask

  // monitor: pops one expectation per result strobe seen
  always @(negedge clk) begin
    if (cellWrEn === 1'b1)
      check_evt("wr_evt", mk(1, int'(cellAddr), int'(cellWrData), int'(currentPlayer), int'(cyc)));
    if (placeOk === 1'b1)
      check_evt("ok_evt", mk(2, int'(cellAddr), 0, int'(currentPlayer), int'(cyc)));
    if (placeReject === 1'b1)
      check_evt("rej_evt", mk(3, int'(cellAddr), 0, int'(currentPlayer), int'(cyc)));
  end

  // driver tasks; keys bits: [4]=enter [3]=right [2]=left [1]=up [0]=down
  task automatic set_keys(input logic [4:0] k);
    enterEn = k[4]; moveRightEn = k[3]; moveLeftEn = k[2]; moveUpEn = k[1]; moveDownEn = k[0];
  endtask

  task automatic check_cursor(input string nm);
    chk({nm, "_x"}, int'(cursorX), mx);
    chk({nm, "_y"}, int'(cursorY), my);
    chk({nm, "_addr"}, int'(cellAddr), my * 8 + mx);
  endtask

  task automatic move(input logic [4:0] k, input string nm);
    set_keys(k);
    @(negedge clk);
    set_keys(5'b0);
    if (k[3]) mx = (mx + 1) % 8;
    else if (k[2]) mx = (mx + 7) % 8;
    else if (k[1]) my = (my + 7) % 8;
    else if (k[0]) my = (my + 1) % 8;
    check_cursor(nm);
  endtask

  task automatic do_enter(input logic [4:0] same_keys, input logic [4:0] busy_keys, input string nm);
    int addr;
    int c;
    addr = my * 8 + mx;
    c = int'(cyc);
    if (bd_model[addr] == 0) begin
      exp_q.push_back(mk(1, addr, (mp != 0) ? 2 : 1, mp, c + 3));
      exp_q.push_back(mk(2, addr, 0, 1 - mp, c + 4));
      bd_model[addr] = (mp != 0) ? 2 : 1;
      mp = 1 - mp;
      rej_model = 0;
    end else begin
      exp_q.push_back(mk(3, addr, 0, mp, c + 3));
      if (rej_model < 255) rej_model++;
    end
    set_keys({1'b1, same_keys[3:0]});
    @(negedge clk);
    chk({nm, "_busy_hi"}, int'(busy), 1);
    set_keys(busy_keys);
    @(negedge clk);
    set_keys(5'b0);
    repeat (4) @(negedge clk);
    chk({nm, "_busy_lo"}, int'(busy), 0);
    chk({nm, "_drained"}, exp_q.size(), 0);
    chk({nm, "_player"}, int'(currentPlayer), mp);
    chk({nm, "_wrdata"}, int'(cellWrData), (mp != 0) ? 2 : 1);
    check_cursor(nm);
`ifdef REVERSI_REJECT_COUNT_EN
    chk({nm, "_rejcnt"}, int'(rejectCount), rej_model);
`endif
  endtask

  task automatic check_idle_reset(input string nm);
    chk({nm, "_x"}, int'(cursorX), 0);
    chk({nm, "_y"}, int'(cursorY), 0);
    chk({nm, "_player"}, int'(currentPlayer), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_wren"}, int'(cellWrEn), 0);
    chk({nm, "_ok"}, int'(placeOk), 0);
    chk({nm, "_rej"}, int'(placeReject), 0);
    chk({nm, "_wrdata"}, int'(cellWrData), 1);
`ifdef REVERSI_REJECT_COUNT_EN
    chk({nm, "_rejcnt"}, int'(rejectCount), 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 2'b00;
      bd_model[i] = 0;
    end
    ram[45] = 2'b01; bd_model[45] = 1;   // (5,5) black
    ram[47] = 2'b11; bd_model[47] = 3;   // (7,5) reserved code
    mx = 0; my = 0; mp = 0; rej_model = 0;
    set_keys(5'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_reset("reset");
    reset = 1'b0;
    @(negedge clk);

    // cursor moves to (3,2)
    repeat (3) move(5'b01000, "right");
    repeat (2) move(5'b00001, "down");
    chk("addr_3_2", int'(cellAddr), 19);

    // wrap-around at both edges
    repeat (3) move(5'b00100, "left");
    repeat (2) move(5'b00010, "up");
    move(5'b00100, "wrap_left");
    move(5'b00010, "wrap_up");
    chk("wrap_7_7", int'(cellAddr), 63);
    move(5'b01000, "wrap_right");
    move(5'b00001, "wrap_down");
    chk("wrap_0_0", int'(cellAddr), 0);

    // placements at (3,3) and (4,4)
    repeat (3) move(5'b01000, "to33_r");
    repeat (3) move(5'b00001, "to33_d");
    do_enter(5'b0, 5'b0, "place33");
    chk("place33_ram", int'(ram[27]), 1);
    move(5'b01000, "to44_r");
    move(5'b00001, "to44_d");
    do_enter(5'b0, 5'b0, "place44");
    chk("place44_ram", int'(ram[36]), 2);

    // rejects at occupied (5,5), then success at (6,5) clears the count
    move(5'b01000, "to55_r");
    move(5'b00001, "to55_d");
    do_enter(5'b0, 5'b0, "reject1");
    do_enter(5'b0, 5'b0, "reject2");
    chk("reject_ram_kept", int'(ram[45]), 1);
    move(5'b01000, "to65");
    do_enter(5'b0, 5'b0, "place65");
    move(5'b01000, "to75");
    do_enter(5'b0, 5'b0, "reject_rsv");

    // enter with a move in the same cycle, then a move during READ
    move(5'b01000, "to05");
    do_enter(5'b01000, 5'b0, "enter_plus_right");
    chk("epr_ram", int'(ram[40]), 2);
    move(5'b01000, "to15");
    do_enter(5'b0, 5'b01000, "move_in_read");
    chk("mir_ram", int'(ram[41]), 1);

    // move priority
    move(5'b01111, "prio_right");
    move(5'b00111, "prio_left");
    move(5'b00011, "prio_up");
    move(5'b00001, "prio_down");
    move(5'b01000, "to25");

    // reset sampled while in CHECK of a valid placement at (2,5)
    set_keys(5'b10000);
    @(negedge clk);
    set_keys(5'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mx = 0; my = 0; mp = 0; rej_model = 0;
    check_idle_reset("mid_reset");
    repeat (4) @(negedge clk);
    chk("mid_reset_ram", int'(ram[42]), 0);
    chk("mid_reset_drained", exp_q.size(), 0);

    // normal operation after reset
    do_enter(5'b0, 5'b0, "post_reset");

    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reversi_move_ctrl.md
Name: reversi_move_ctrl

Overview:
- Turn/cursor controller between the keyboard interpreter and the board-state RAM.
- Consumes one-cycle key enables (enter, right, left, up, down) and moves a cursor on the board with wrap-around.
- On enter, performs a read-check-write on the cursor cell. An empty cell gets the current player's piece and the turn passes; an occupied cell is rejected.
- Feeds cursor position and current player to the display logic.

Parameters:
- BOARD_DIM, 8, board side length in cells; must be a power of two, at least 2.
- COORD_W, 3, coordinate width; equals log2(BOARD_DIM).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enterEn  in  1  one-cycle pulse: place piece at cursor.
- moveRightEn  in  1  one-cycle pulse: x+1.
- moveLeftEn  in  1  one-cycle pulse: x-1.
- moveUpEn  in  1  one-cycle pulse: y-1.
- moveDownEn  in  1  one-cycle pulse: y+1.
- cellRdData  in  2  board RAM read data for cellAddr: 00 empty, 01 black, 10 white, 11 reserved (treated as occupied).
- cursorX  out  COORD_W  cursor column.
- cursorY  out  COORD_W  cursor row.
- cellAddr  out  2*COORD_W  board RAM address = {cursorY, cursorX}; read and write share this address.
- cellWrEn  out  1  board RAM write strobe.
- cellWrData  out  2  piece written: 01 when currentPlayer=0, 10 when currentPlayer=1.
- currentPlayer  out  1  0 = black, 1 = white.
- busy  out  1  high in any state other than IDLE.
- placeOk  out  1  one-cycle pulse: placement succeeded.
- placeReject  out  1  one-cycle pulse: cell was occupied.

Behaviour:
- Reset values: cursorX=0, cursorY=0, currentPlayer=0, state=IDLE, cellWrEn=0, placeOk=0, placeReject=0, busy=0. cellWrData follows currentPlayer.
- All outputs are registered, except cellAddr (combinational concatenation of the cursor registers) and busy (decoded from state).
- Board RAM has 1-cycle synchronous read latency: cellRdData for the address presented in cycle N is valid in cycle N+1.
- FSM states: IDLE, READ, CHECK, WRITE.
- IDLE:
  - enterEn=1 -> READ. Cursor frozen.
  - else any move enable -> update cursor in the same edge and stay in IDLE.
- READ: unconditional -> CHECK. Cursor and address held stable.
- CHECK: sample cellRdData.
  - 00 -> WRITE, with cellWrEn=1 registered for exactly one cycle in the WRITE state.
  - non-00 -> IDLE, with placeReject pulsed one cycle and player unchanged.
- WRITE: -> IDLE. On the same edge: currentPlayer toggles and placeOk pulses one cycle.
- Latency, with enterEn sampled at edge T:
  - READ at T+1, CHECK at T+2.
  - cellWrEn high during cycle T+3.
  - currentPlayer toggled and placeOk high from T+4.
  - Reject path: placeReject high in cycle T+3, IDLE at T+3.
- Cursor arithmetic is modulo BOARD_DIM:
  - right at x=BOARD_DIM-1 -> 0; left at x=0 -> BOARD_DIM-1.
  - down at y=BOARD_DIM-1 -> 0; up at y=0 -> BOARD_DIM-1.
- Simultaneous inputs in IDLE:
  - enterEn beats all moves; the moves are dropped.
  - Among moves, exactly one is applied, priority right > left > up > down.
- All key enables received while busy=1 are ignored, not queued.
- Reset has priority over everything. Reset asserted mid-operation (any state) returns to IDLE on the next edge with all reset values. A pending write is abandoned: cellWrEn is low in the cycle after reset is sampled.

Optional Feature:
- Macro: REVERSI_REJECT_COUNT_EN.
- Defined:
  - Adds output port rejectCount (8 bits).
  - Increments by 1 on each placeReject pulse, saturating at 255.
  - Cleared by reset. Cleared on each placeOk, so it counts consecutive invalid attempts by the current player.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then moveRightEn x3, moveDownEn x2 -> cursorX=3, cursorY=2, cellAddr=6'b010011.
- Cursor at (0,0), moveLeftEn then moveUpEn -> (7,7). Cursor at (7,7), moveRightEn then moveDownEn -> (0,0).
- Cursor (3,3), cellRdData=00, enterEn at edge T -> cellWrEn=1 with cellAddr=27 and cellWrData=01 during T+3; placeOk=1 and currentPlayer=1 at T+4. Repeat at (4,4) -> cellWrData=10, currentPlayer back to 0.
- cellRdData=01 at cursor, enterEn -> placeReject single pulse at T+3, cellWrEn never high, currentPlayer unchanged. With REVERSI_REJECT_COUNT_EN: two rejects give rejectCount=2; a following placeOk gives rejectCount=0.
- enterEn with moveRightEn same cycle -> cursor unchanged, write occurs at original cell. moveRightEn during READ -> ignored, cursor unchanged after return to IDLE.
- Assert reset in cycle T+2 of a valid placement -> cellWrEn stays 0, state IDLE, cursor (0,0), currentPlayer=0, no placeOk.
